// File: rtl/scalar_wb_pkg.sv
// Shared types for the scalar writeback unit: default widths, the write request
// record and the per-cycle write source encoding.
package scalar_wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dst;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small in-order holding buffer for ALU results that lose the writeback slot.
// Power-of-two depth; push while full is accepted only together with a pop.
module wb_skid_fifo
    import scalar_wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type req_t = wb_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  req_t push_data_i,
    input  logic pop_i,
    output req_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    req_t               mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign head_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Storage array; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/scalar_writeback_unit.sv
// Scalar register file write port: arbitrates loads, queued and direct ALU results,
// keeps the pending scoreboard. Optional macro WB_BYPASS_EN adds write forwarding.
module scalar_writeback_unit
    import scalar_wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_dst_i,
    output logic              iss_ready_o,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_dst_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_dst_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [ADDR_W-1:0] chk_addr_1_i,
    input  logic [ADDR_W-1:0] chk_addr_2_i,
    output logic              busy_1_o,
    output logic              busy_2_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_dst_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wb_err_o
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd_hit_1_o,
    output logic              fwd_hit_2_o,
    output logic [DATA_W-1:0] fwd_data_1_o,
    output logic [DATA_W-1:0] fwd_data_2_o
`endif
);

    localparam int NREG = 2 ** ADDR_W;

    // Same layout as wb_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              sel_s;
    req_t              fifo_head_s;
    req_t              alu_req_s;
    wb_src_e           src_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              alu_acc_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_fire_s;
    logic              err_hit_s;
    logic [NREG-1:0]   pending_d;
    logic [NREG-1:0]   pending_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_dst_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wb_err_q;
    logic              hit_1_s;
    logic              hit_2_s;

    assign alu_req_s   = '{dst: alu_dst_i, data: alu_data_i};
    assign alu_ready_o = !fifo_full_s;
    assign alu_acc_s   = alu_valid_i && !fifo_full_s;
    assign iss_ready_o = !pending_q[iss_dst_i];

    wb_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .req_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (alu_req_s),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Write source priority: load, then oldest queued ALU result, then live ALU.
    always_comb begin
        src_s = SRC_NONE;
        sel_s = '0;
        if (ld_valid_i) begin
            src_s = SRC_LOAD;
            sel_s = '{dst: ld_dst_i, data: ld_data_i};
        end else if (!fifo_empty_s) begin
            src_s = SRC_FIFO;
            sel_s = fifo_head_s;
        end else if (alu_acc_s) begin
            src_s = SRC_ALU;
            sel_s = alu_req_s;
        end else begin
            src_s = SRC_NONE;
            sel_s = '0;
        end
    end

    assign pop_s     = (src_s == SRC_FIFO);
    assign push_s    = alu_acc_s && (src_s != SRC_ALU);
    assign wr_fire_s = (src_s != SRC_NONE) && (sel_s.dst != {ADDR_W{1'b0}});
    assign err_hit_s = wr_fire_s && !pending_q[sel_s.dst];

    // Scoreboard next state: clear on the write cycle, a new reservation wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[wr_dst_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (iss_valid_i && iss_ready_o) begin
            pending_d[iss_dst_i] = 1'b1;
        end else begin
            pending_d[iss_dst_i] = pending_d[iss_dst_i];
        end
        pending_d[0] = 1'b0;
    end

    // Output write register, scoreboard and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_dst_q  <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            wb_err_q  <= 1'b0;
            pending_q <= {NREG{1'b0}};
        end else begin
            wr_en_q   <= wr_fire_s;
            if (wr_fire_s) begin
                wr_dst_q  <= sel_s.dst;
                wr_data_q <= sel_s.data;
            end
            wb_err_q  <= wb_err_q || err_hit_s;
            pending_q <= pending_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_dst_o  = wr_dst_q;
    assign wr_data_o = wr_data_q;
    assign wb_err_o  = wb_err_q;

`ifdef WB_BYPASS_EN
    // A write in flight satisfies a reader this cycle; pending is still set until the edge.
    assign hit_1_s      = wr_en_q && (wr_dst_q == chk_addr_1_i) && (chk_addr_1_i != {ADDR_W{1'b0}});
    assign hit_2_s      = wr_en_q && (wr_dst_q == chk_addr_2_i) && (chk_addr_2_i != {ADDR_W{1'b0}});
    assign fwd_hit_1_o  = hit_1_s;
    assign fwd_hit_2_o  = hit_2_s;
    assign fwd_data_1_o = wr_data_q;
    assign fwd_data_2_o = wr_data_q;
`else
    assign hit_1_s = 1'b0;
    assign hit_2_s = 1'b0;
`endif

    assign busy_1_o = pending_q[chk_addr_1_i] && !hit_1_s;
    assign busy_2_o = pending_q[chk_addr_2_i] && !hit_2_s;

endmodule

// File: tb/tb_scalar_writeback_unit.sv
// Directed self-checking bench for scalar_writeback_unit (default or WB_BYPASS_EN build).
module tb_scalar_writeback_unit;
    import scalar_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [3:0]  iss_dst;
    logic        iss_ready;
    logic        alu_valid;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_dst;
    logic [15:0] ld_data;
    logic [3:0]  chk_addr_1;
    logic [3:0]  chk_addr_2;
    logic        busy_1;
    logic        busy_2;
    logic        wr_en;
    logic [3:0]  wr_dst;
    logic [15:0] wr_data;
    logic        wb_err;
`ifdef WB_BYPASS_EN
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [15:0] fwd_data_1;
    logic [15:0] fwd_data_2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    scalar_writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid_i  (iss_valid),
        .iss_dst_i    (iss_dst),
        .iss_ready_o  (iss_ready),
        .alu_valid_i  (alu_valid),
        .alu_dst_i    (alu_dst),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready),
        .ld_valid_i   (ld_valid),
        .ld_dst_i     (ld_dst),
        .ld_data_i    (ld_data),
        .chk_addr_1_i (chk_addr_1),
        .chk_addr_2_i (chk_addr_2),
        .busy_1_o     (busy_1),
        .busy_2_o     (busy_2),
        .wr_en_o      (wr_en),
        .wr_dst_o     (wr_dst),
        .wr_data_o    (wr_data),
        .wb_err_o     (wb_err)
`ifdef WB_BYPASS_EN
        ,
        .fwd_hit_1_o  (fwd_hit_1),
        .fwd_hit_2_o  (fwd_hit_2),
        .fwd_data_1_o (fwd_data_1),
        .fwd_data_2_o (fwd_data_2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_dst = 4'd0;
        alu_valid = 1'b0; alu_dst = 4'd0; alu_data = 16'h0000;
        ld_valid  = 1'b0; ld_dst  = 4'd0; ld_data  = 16'h0000;
    endtask

    task automatic expect_wr(input string tag, input logic [3:0] dst, input logic [15:0] data);
        check_eq({tag, "_en"},   {31'd0, wr_en}, 32'd1);
        check_eq({tag, "_dst"},  {28'd0, wr_dst}, {28'd0, dst});
        check_eq({tag, "_data"}, {16'd0, wr_data}, {16'd0, data});
    endtask

    task automatic issue(input logic [3:0] d);
        iss_valid = 1'b1; iss_dst = d;
        #1;
        check_eq("iss_ready", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        chk_addr_1 = 4'd0; chk_addr_2 = 4'd0;
        #12;
        check_eq("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        check_eq("rst_wr_dst",  {28'd0, wr_dst}, 32'd0);
        check_eq("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check_eq("rst_wb_err",  {31'd0, wb_err}, 32'd0);
        check_eq("rst_alu_rdy", {31'd0, alu_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Issue r3 then ALU r3: written one cycle after acceptance.
        issue(4'd3);
        chk_addr_1 = 4'd3;
        #1;
        check_eq("t2_busy_pre", {31'd0, busy_1}, 32'd1);
        alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h1234;
        #1;
        check_eq("t2_alu_rdy", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        expect_wr("t2_wr", 4'd3, 16'h1234);
`ifdef WB_BYPASS_EN
        check_eq("t2_busy_wcyc", {31'd0, busy_1}, 32'd0);
        check_eq("t2_fwd_hit",   {31'd0, fwd_hit_1}, 32'd1);
`else
        check_eq("t2_busy_wcyc", {31'd0, busy_1}, 32'd1);
`endif
        tick();
        check_eq("t2_wr_en_off", {31'd0, wr_en}, 32'd0);
        check_eq("t2_hold_data", {16'd0, wr_data}, 32'h1234);
        check_eq("t2_busy_post", {31'd0, busy_1}, 32'd0);

        // Load and ALU together: load first, ALU from the FIFO next cycle.
        issue(4'd5);
        issue(4'd6);
        ld_valid  = 1'b1; ld_dst  = 4'd5; ld_data  = 16'hAAAA;
        alu_valid = 1'b1; alu_dst = 4'd6; alu_data = 16'h5555;
        tick();
        idle_inputs();
        expect_wr("t3_ld", 4'd5, 16'hAAAA);
        tick();
        expect_wr("t3_alu", 4'd6, 16'h5555);
        tick();
        check_eq("t3_idle", {31'd0, wr_en}, 32'd0);

        // Loads held 3 cycles while ALU streams r8..r11.
        for (int r = 8; r <= 14; r++) issue(4'(r));
        ld_valid = 1'b1; ld_dst = 4'd12; ld_data = 16'hC00C;
        alu_valid = 1'b1; alu_dst = 4'd8; alu_data = 16'h0008;
        tick();
        expect_wr("t4_c0", 4'd12, 16'hC00C);
        ld_dst = 4'd13; ld_data = 16'hC00D;
        alu_dst = 4'd9; alu_data = 16'h0009;
        #1;
        check_eq("t4_rdy_1q", {31'd0, alu_ready}, 32'd1);
        tick();
        expect_wr("t4_c1", 4'd13, 16'hC00D);
        ld_dst = 4'd14; ld_data = 16'hC00E;
        alu_dst = 4'd10; alu_data = 16'h000A;
        #1;
        check_eq("t4_rdy_full", {31'd0, alu_ready}, 32'd0);
        tick();
        expect_wr("t4_c2", 4'd14, 16'hC00E);
        ld_valid = 1'b0;
        #1;
        check_eq("t4_rdy_full2", {31'd0, alu_ready}, 32'd0);
        tick();
        expect_wr("t4_c3", 4'd8, 16'h0008);
        #1;
        check_eq("t4_rdy_again", {31'd0, alu_ready}, 32'd1);
        tick();
        expect_wr("t4_c4", 4'd9, 16'h0009);
        alu_dst = 4'd11; alu_data = 16'h000B;
        tick();
        expect_wr("t4_c5", 4'd10, 16'h000A);
        alu_valid = 1'b0;
        tick();
        expect_wr("t4_c6", 4'd11, 16'h000B);
        tick();
        check_eq("t4_idle", {31'd0, wr_en}, 32'd0);
        check_eq("t4_no_err", {31'd0, wb_err}, 32'd0);

        // Writes to r0 are swallowed; a write to non-pending r7 flags an error.
        alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 16'hFFFF;
        tick();
        check_eq("t5_r0_en", {31'd0, wr_en}, 32'd0);
        check_eq("t5_r0_err", {31'd0, wb_err}, 32'd0);
        alu_dst = 4'd7; alu_data = 16'h0777;
        tick();
        alu_valid = 1'b0;
        expect_wr("t5_r7", 4'd7, 16'h0777);
        check_eq("t5_err_set", {31'd0, wb_err}, 32'd1);
        tick();
        tick();
        check_eq("t5_err_sticky", {31'd0, wb_err}, 32'd1);

        // Back-to-back issue of r4 stalls until the r4 write is registered.
        issue(4'd4);
        iss_valid = 1'b1; iss_dst = 4'd4;
        chk_addr_1 = 4'd4; chk_addr_2 = 4'd4;
        alu_valid = 1'b1; alu_dst = 4'd4; alu_data = 16'h4444;
        #1;
        check_eq("t6_stall", {31'd0, iss_ready}, 32'd0);
        tick();
        alu_valid = 1'b0;
        expect_wr("t6_wr", 4'd4, 16'h4444);
        check_eq("t6_stall_wcyc", {31'd0, iss_ready}, 32'd0);
`ifdef WB_BYPASS_EN
        check_eq("t6_fwd_hit",  {31'd0, fwd_hit_1}, 32'd1);
        check_eq("t6_fwd_data", {16'd0, fwd_data_1}, 32'h4444);
        check_eq("t6_busy_fwd", {31'd0, busy_1}, 32'd0);
`else
        check_eq("t6_busy_wcyc", {31'd0, busy_1}, 32'd1);
`endif
        tick();
        check_eq("t6_ready", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check_eq("t6_rereserved", {31'd0, busy_2}, 32'd1);

        // Reset mid-run with a result queued in the FIFO.
        ld_valid = 1'b1; ld_dst = 4'd4; ld_data = 16'h0404;
        alu_valid = 1'b1; alu_dst = 4'd2; alu_data = 16'h0202;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq("t1_wr_en",  {31'd0, wr_en}, 32'd0);
        check_eq("t1_wb_err", {31'd0, wb_err}, 32'd0);
        check_eq("t1_busy_1", {31'd0, busy_1}, 32'd0);
        check_eq("t1_busy_2", {31'd0, busy_2}, 32'd0);
        check_eq("t1_alu_rdy", {31'd0, alu_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check_eq("t1_post_en",  {31'd0, wr_en}, 32'd0);
        check_eq("t1_post_err", {31'd0, wb_err}, 32'd0);
        check_eq("t1_post_rdy", {31'd0, alu_ready}, 32'd1);
        tick();
        check_eq("t1_fifo_gone", {31'd0, wr_en}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
